sprite_anim_renderer: RTL and testbench

//  Parametrised multi-frame sprite renderer for the VGA pipeline: plays an N-frame sprite sheet at a movable
//  on-screen position, with per-frame animation stepping, one-shot/loop modes and index-0 transparency.

---
 rtl/sprite_anim_renderer.sv | 225 ++++++++++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_renderer
// Description : Multi-frame sprite renderer for the VGA pipeline. Plays an
//               N-frame sprite sheet at a frame-latched screen position with
//               per-frame animation stepping, loop/one-shot modes and
//               index-0 transparency. Drives an external registered sprite
//               ROM and produces pix_on/pix_idx two clocks after DrawX/DrawY.
// Options     : SPRITE_MIRROR_EN - when defined, flip is latched at frame
//               start and mirrors the sprite horizontally.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_anim_renderer #(
  parameter int SPR_W      = 50,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  parameter int IDX_W      = 3,
  parameter int ADDR_W     = 14,
  parameter int TICKS      = 6,
  // Derived width of frame_num; not intended to be overridden.
  parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               vs,
  input  logic [9:0]         sprite_x,
  input  logic [9:0]         sprite_y,
  input  logic               flip,
  input  logic               loop,
  input  logic               play,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic               pix_on,
  output logic [IDX_W-1:0]   pix_idx,
  output logic [FRAME_W-1:0] frame_num,
  output logic               busy,
  output logic               done
);

  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Animation control state
  logic [1:0]         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [TICK_W-1:0]  ticks_q, ticks_d;
  logic               done_q, done_d;

  // Frame-start detection and latched position
  logic               vs_q, vs_d;
  logic [9:0]         px_q, px_d;
  logic [9:0]         py_q, py_d;

  // Pixel pipeline
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               hit_dly_q, hit_dly_d;
  logic               pix_on_q, pix_on_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;

  logic               w_frame_start;
  logic               w_tick_wrap;
  logic               w_last_frame;
  logic               w_step;
  logic               w_wrap_last;
  logic [10:0]        w_x_end;
  logic [10:0]        w_y_end;
  logic               w_hit;
  logic [9:0]         w_dx;
  logic [9:0]         w_col;
  logic [9:0]         w_row;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_opaque;

`ifdef SPRITE_MIRROR_EN
  logic               flip_q, flip_d;
`else
  logic               w_unused_flip;
  assign w_unused_flip = flip;
`endif

  // A new video frame starts on the first cycle vs is seen low after being high.
  assign w_frame_start = vs_q & ~vs;
  assign w_tick_wrap   = (ticks_q == TICK_W'(TICKS - 1));
  assign w_last_frame  = (frame_q == FRAME_W'(NUM_FRAMES - 1));
  assign w_step        = (state_q == S_PLAY) && w_frame_start;
  assign w_wrap_last   = w_step && w_tick_wrap && w_last_frame;

  // FSM state register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: play restarts from any state; one-shot parks in HOLD at the end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (play) state_d = S_PLAY;
      S_PLAY: begin
        if (play) begin
          state_d = S_PLAY;
        end else if (w_wrap_last && !loop) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (play) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: frame/tick stepping at frame start, done pulse, busy flag
  always_comb begin
    frame_d = frame_q;
    ticks_d = ticks_q;
    done_d  = 1'b0;
    busy    = (state_q == S_PLAY);
    if (play) begin
      // A play pulse overrides any advance due in the same cycle.
      frame_d = '0;
      ticks_d = '0;
    end else if (w_step) begin
      if (w_tick_wrap) begin
        ticks_d = '0;
        if (!w_last_frame) begin
          frame_d = frame_q + FRAME_W'(1);
        end else if (loop) begin
          frame_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        ticks_d = ticks_q + TICK_W'(1);
      end
    end
  end

  // Position latch: sampled only at frame start so a frame never tears
  always_comb begin
    vs_d = vs;
    px_d = w_frame_start ? sprite_x : px_q;
    py_d = w_frame_start ? sprite_y : py_q;
`ifdef SPRITE_MIRROR_EN
    flip_d = w_frame_start ? flip : flip_q;
`endif
  end

  // Hit test in 11 bits so sprites near the right/bottom edge clip instead of wrapping.
  assign w_x_end = {1'b0, px_q} + 11'(SPR_W);
  assign w_y_end = {1'b0, py_q} + 11'(SPR_H);
  assign w_hit   = blank
                && (DrawX >= px_q) && ({1'b0, DrawX} < w_x_end)
                && (DrawY >= py_q) && ({1'b0, DrawY} < w_y_end);

  assign w_dx  = DrawX - px_q;
  assign w_row = DrawY - py_q;
`ifdef SPRITE_MIRROR_EN
  assign w_col = flip_q ? (10'(SPR_W - 1) - w_dx) : w_dx;
`else
  assign w_col = w_dx;
`endif

  // Frame-major sheet layout: frame*W*H + row*W + col.
  assign w_addr = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(w_row)   * ADDR_W'(SPR_W)
                + ADDR_W'(w_col);

  // Pipeline next values: address held when off-sprite to avoid ROM toggling
  always_comb begin
    rom_addr_d = w_hit ? w_addr : rom_addr_q;
    hit_dly_d  = w_hit;
    w_opaque   = hit_dly_q && (rom_q != '0);
    pix_on_d   = w_opaque;
    pix_idx_d  = w_opaque ? rom_q : '0;
  end

  // Datapath and animation registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q    <= '0;
      ticks_q    <= '0;
      done_q     <= 1'b0;
      vs_q       <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
`ifdef SPRITE_MIRROR_EN
      flip_q     <= 1'b0;
`endif
      rom_addr_q <= '0;
      hit_dly_q  <= 1'b0;
      pix_on_q   <= 1'b0;
      pix_idx_q  <= '0;
    end else begin
      frame_q    <= frame_d;
      ticks_q    <= ticks_d;
      done_q     <= done_d;
      vs_q       <= vs_d;
      px_q       <= px_d;
      py_q       <= py_d;
`ifdef SPRITE_MIRROR_EN
      flip_q     <= flip_d;
`endif
      rom_addr_q <= rom_addr_d;
      hit_dly_q  <= hit_dly_d;
      pix_on_q   <= pix_on_d;
      pix_idx_q  <= pix_idx_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_on    = pix_on_q;
  assign pix_idx   = pix_idx_q;
  assign frame_num = frame_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_anim_renderer
// Description : Self-checking bench for sprite_anim_renderer. Pixel outputs
//               are checked through a scoreboard queue; animation control
//               is checked at hand-derived points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_renderer;

  localparam int SPR_W = 50;
  localparam int SPR_H = 64;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic        blank, vs, flip, loop, play;
  logic [13:0] rom_addr;
  logic [2:0]  rom_q;
  logic        pix_on;
  logic [2:0]  pix_idx;
  logic [1:0]  frame_num;
  logic        busy, done;

  typedef struct packed { logic on; logic [2:0] idx; } pix_t;
  typedef struct { int x; int y; bit b; bit hit; } vec_t;

  pix_t sb[$];
  pix_t chk_e;
  vec_t tbl_a[11];
  vec_t tbl_b[6];

  int errors = 0;
  int checks = 0;

  // Reference model of the latched sprite state, maintained by the test itself
  int m_px = 0, m_py = 0, m_frame = 0;
  bit m_flip = 1'b0;

  sprite_anim_renderer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .vs(vs), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .flip(flip), .loop(loop), .play(play), .rom_addr(rom_addr), .rom_q(rom_q),
    .pix_on(pix_on), .pix_idx(pix_idx), .frame_num(frame_num),
    .busy(busy), .done(done)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] rom_val(input int a);
    return 3'((a + 5) % 7);
  endfunction

  // Sprite ROM contents as seen on the registered address
  always_comb rom_q = rom_val(int'(rom_addr));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; pushes the pixel expected two clocks later.
  task automatic cyc(input int x, input int y, input bit b, input bit v,
                     input bit p, input bit h);
    pix_t e;
    int col, addr;
    logic [2:0] q;
    @(posedge vga_clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); blank = b; vs = v; play = p;
    col = x - m_px;
`ifdef SPRITE_MIRROR_EN
    if (m_flip) col = SPR_W - 1 - col;
`endif
    addr  = m_frame * SPR_W * SPR_H + (y - m_py) * SPR_W + col;
    q     = rom_val(addr);
    e.on  = h && (q != 3'd0);
    e.idx = e.on ? q : 3'd0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // One vs falling edge, then vs back high; returns one clock after the edge is taken
  task automatic vs_frame(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    cyc(v.x, v.y, v.b, 1'b1, 1'b0, v.hit);
  endtask

  // Scoreboard: the oldest of three queued entries is the pixel now on the outputs
  always @(negedge vga_clk) begin
    if (sb.size() >= 3) begin
      chk_e = sb.pop_front();
      check("pix_on", int'(pix_on), int'(chk_e.on));
      check("pix_idx", int'(pix_idx), int'(chk_e.idx));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl_a = '{'{100, 200, 1, 1}, '{101, 200, 1, 1}, '{102, 200, 1, 1},
              '{149, 200, 1, 1}, '{150, 200, 1, 0}, '{ 99, 200, 1, 0},
              '{100, 263, 1, 1}, '{100, 264, 1, 0}, '{120, 230, 1, 1},
              '{120, 230, 0, 0}, '{130, 199, 1, 0}};
    tbl_b = '{'{620, 10, 1, 1}, '{639, 10, 1, 1}, '{625, 12, 1, 1},
              '{  0, 10, 1, 0}, '{ 29, 10, 1, 0}, '{619, 10, 1, 0}};

    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; vs = 1'b1;
    sprite_x = '0; sprite_y = '0; flip = 1'b0; loop = 1'b1; play = 1'b0;
    idle(3);
    check("rst_pix_on", int'(pix_on), 0);
    check("rst_pix_idx", int'(pix_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame", int'(frame_num), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    reset_n = 1'b1;
    idle(2);

    // Position is 0 until the first frame start
    cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Basic drawing at (100,200)
    sprite_x = 10'd100; sprite_y = 10'd200;
    vs_frame(1);
    m_px = 100; m_py = 200;
    cyc(149, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(150, 200, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("rom_addr_hold", int'(rom_addr), 49);
    cyc(100, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("rom_addr_origin", int'(rom_addr), 0);
    foreach (tbl_a[i]) run_vec(tbl_a[i]);
    idle(2);

    // Right-edge clipping and mid-frame position change
    sprite_x = 10'd620; sprite_y = 10'd10;
    vs_frame(1);
    m_px = 620; m_py = 10;
    foreach (tbl_b[i]) run_vec(tbl_b[i]);
    sprite_x = 10'd0;
    cyc(620, 10, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(0, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    vs_frame(1);
    m_px = 0;
    cyc(0, 10, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(620, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Horizontal mirror
    flip = 1'b1; sprite_x = 10'd100; sprite_y = 10'd200;
    vs_frame(1);
    m_px = 100; m_py = 200; m_flip = 1'b1;
    cyc(100, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
`ifdef SPRITE_MIRROR_EN
    check("rom_addr_flip", int'(rom_addr), 49);
`else
    check("rom_addr_flip", int'(rom_addr), 0);
`endif
    cyc(101, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    flip = 1'b0;
    vs_frame(1);
    m_flip = 1'b0;
    check("idle_frame", int'(frame_num), 0);
    check("idle_busy", int'(busy), 0);

    // Looping animation
    loop = 1'b1;
    cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("loop_busy", int'(busy), 1);
    vs_frame(5);
    check("loop_f0_5", int'(frame_num), 0);
    vs_frame(1);
    check("loop_f1", int'(frame_num), 1);
    vs_frame(6);
    check("loop_f2", int'(frame_num), 2);
    m_frame = 2;
    cyc(100, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("rom_addr_f2", int'(rom_addr), 6400);
    vs_frame(6);
    check("loop_f3", int'(frame_num), 3);
    vs_frame(6);
    check("loop_wrap", int'(frame_num), 0);
    check("loop_wrap_busy", int'(busy), 1);
    check("loop_wrap_done", int'(done), 0);
    m_frame = 0;
    cyc(120, 230, 1'b1, 1'b1, 1'b0, 1'b1);
    // play coincident with the advancing frame start
    vs_frame(5);
    cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("play_wins", int'(frame_num), 0);
    vs_frame(5);
    check("play_wins_5", int'(frame_num), 0);
    vs_frame(1);
    check("play_wins_6", int'(frame_num), 1);

    // One-shot animation
    loop = 1'b0;
    cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("oneshot_start", int'(frame_num), 0);
    vs_frame(18);
    check("oneshot_f3", int'(frame_num), 3);
    check("oneshot_busy", int'(busy), 1);
    vs_frame(5);
    check("oneshot_nodone", int'(done), 0);
    vs_frame(1);
    check("oneshot_done", int'(done), 1);
    check("oneshot_hold_busy", int'(busy), 0);
    check("oneshot_hold_frame", int'(frame_num), 3);
    idle(1);
    check("oneshot_done_pulse", int'(done), 0);
    vs_frame(6);
    check("hold_frozen", int'(frame_num), 3);
    check("hold_done", int'(done), 0);
    m_frame = 3;
    cyc(101, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(120, 230, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("replay_frame", int'(frame_num), 0);
    check("replay_busy", int'(busy), 1);
    vs_frame(6);
    check("replay_f1", int'(frame_num), 1);
    m_frame = 1;

    // Asynchronous reset in the middle of a pixel stream
    for (int i = 0; i < 4; i++) cyc(103 + i, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_pix_on", int'(pix_on), 0);
    check("mid_rst_pix_idx", int'(pix_idx), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_frame", int'(frame_num), 0);
    sb.delete();
    repeat (3) sb.push_back('0);
    idle(3);
    reset_n = 1'b1;
    m_px = 0; m_py = 0; m_frame = 0;
    idle(1);
    cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    vs_frame(1);
    m_px = 100; m_py = 200;
    cyc(100, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
